ddram_toggle_bridge: RTL and testbench
======================================

# ddram_toggle_bridge

Responder side of the toggle-handshake ROM port: accepts 16-bit write requests from the download path and byte read requests from the console core, and turns them into single-beat transactions on the 64-bit DDR3 Avalon interface. It sits between the top-level ROM loader/`pce_top` ROM read port and the `DDRAM_*` pins, clocked by the memory clock. An optional one-line read cache serves repeat reads of the same 8-byte word without a DDR3 round trip.

## Interface
- `BASE_ADDR`, default 29'h0600_0000: DDR3 word (8-byte) address of ROM byte 0, which is byte address 0x3000_0000.
- `DDRAM_CLK` input 1: the only clock. `DDRAM_CLK` is also the clock seen by the DDR3 port.
- `reset` input 1: asynchronous, active-high.
- `wraddr` input 28: byte address of the write. Bit 0 is ignored.
- `din` input 16: write data.
- `we_req` input 1: write request toggle.
- `we_ack` output 1: write acknowledge toggle.
- `rdaddr` input 28: byte address of the read.
- `dout` output 8: read data.
- `rd_req` input 1: read request toggle.
- `rd_ack` output 1: read acknowledge toggle.
- `DDRAM_BUSY` input 1: waitrequest.
- `DDRAM_BURSTCNT` output 8: burst count. Constant 1.
- `DDRAM_ADDR` output 29: word address.
- `DDRAM_DOUT` input 64: read data.
- `DDRAM_DOUT_READY` input 1: read data valid.
- `DDRAM_RD` output 1: read command.
- `DDRAM_DIN` output 64: write data.
- `DDRAM_BE` output 8: byte enables.
- `DDRAM_WE` output 1: write command.

## Operation
- **Pending requests.** A request is pending while `req != ack`. Requests are sampled only in IDLE. Address and data are registered at acceptance, and later input changes are ignored.
- **States:**
  - IDLE → WR_CMD when a write is pending. Writes have priority over reads when both are pending.
  - IDLE → RD_CMD when a read is pending and misses the cache.
  - IDLE stays IDLE on a cache hit.
  - WR_CMD → IDLE when the command is accepted (`DDRAM_BUSY` low at the edge). `we_ack` toggles at that edge.
  - RD_CMD → RD_WAIT when the command is accepted.
  - RD_WAIT → IDLE on `DDRAM_DOUT_READY`. At that edge the line is filled, `dout` is loaded, and `rd_ack` toggles.
- **Address mapping.** `DDRAM_ADDR = BASE_ADDR + addr[27:3]`, modulo 2^29, so it wraps.
- **Write data.** `DDRAM_DIN = {4{din}}`. `DDRAM_BE = 8'b11 << (2*wraddr[2:1])`.
- **Read data.** `dout = line[8*rdaddr[2:0] +: 8]`.
- **Cache line.** One valid bit, a 25-bit tag (`addr[27:3]`) and 64 data bits.
  - Hit: valid and the tag matches `rdaddr[27:3]`.
  - A write whose `wraddr[27:3]` matches a valid tag updates the two selected line bytes in the same cycle as the write command is accepted (write-through).
- `DDRAM_DOUT_READY` is ignored outside RD_WAIT.
- New toggles arriving while busy stay pending and are serviced after the return to IDLE.

## Timing
- **Reset values:** `we_ack`=0, `rd_ack`=0, `dout`=0, `DDRAM_RD`=0, `DDRAM_WE`=0, `DDRAM_ADDR`=0, `DDRAM_DIN`=0, `DDRAM_BE`=0, `DDRAM_BURSTCNT`=1. Cache invalid, state IDLE.
- `DDRAM_RD`/`DDRAM_WE` are asserted in the cycle after acceptance. They are held, with `DDRAM_ADDR`, `DDRAM_DIN` and `DDRAM_BE`, until an edge where `DDRAM_BUSY`=0, then deasserted at that edge.
- Cache-hit read latency: `rd_ack` toggles 1 cycle after the toggle is seen in IDLE.
- Miss latency: 1 cycle + BUSY stall + DDR3 latency + 0 cycles. `dout` and `rd_ack` update at the `DOUT_READY` edge.
- Back-to-back: the next request can be accepted in the cycle after the state returns to IDLE.
- **Reset mid-transaction** aborts immediately: outputs go to reset values and pending toggles are dropped, because both ack registers are 0. Upstream must reissue with `req`=ack+1. Upstream resets request toggles together with this block; the loader does so on reset.

## Configuration
- `DDRAM_RDCACHE_EN` defined: the cache line, the hit path and write-through update exist as described.
- Not defined: every read goes IDLE→RD_CMD→RD_WAIT, there is no line storage, and `dout` comes straight from the registered `DDRAM_DOUT` byte. Write behaviour is identical in both builds.

## Structure
- Package `ddram_bridge_pkg` holds:
  - state enum (IDLE, WR_CMD, RD_CMD, RD_WAIT)
  - `DDRAM_BASE_DEFAULT` constant
  - function `be16(addr[2:1])` returning 8-bit byte enables
  - function `sel8(line, addr[2:0])`
- Sub-module `ddram_rdline`: valid/tag/data storage, hit compare, fill port and write-through merge. Compiled only under `DDRAM_RDCACHE_EN`.

## Test plan
- Write `wraddr`=0x000006, `din`=0xA55A, BUSY=0 → one `DDRAM_WE` cycle, ADDR=0x0600_0000, BE=0xC0, DIN=0xA55A_A55A_A55A_A55A, then `we_ack` toggles.
- Read `rdaddr`=0x000013 (miss), DOUT=0x0011_2233_4455_6677 after 10 cycles → `DDRAM_RD` one cycle, ADDR=0x0600_0002, `dout`=0x44, `rd_ack` toggles. Then read 0x000010 → no `DDRAM_RD`, `dout`=0x77 after 1 cycle.
- Write and read toggles in the same cycle, write to a cached line at 0x000012 with `din`=0xBEEF → write first, then read of 0x000013 hits and returns 0xBE.
- Hold BUSY=1 for 5 cycles during RD_CMD → RD, ADDR stable for 6 cycles. One spurious DOUT_READY in IDLE → no ack change.
- Assert `reset` during RD_WAIT → all outputs at reset values in the same cycle. A later read of a previously cached address → DDR3 read issued.
- Build without `DDRAM_RDCACHE_EN`, two identical reads → two `DDRAM_RD` transactions.

Source files
------------

// File: rtl/ddram_bridge_pkg.sv
// Shared types and helpers for the DDR3 toggle-handshake ROM bridge.
// Optional read cache is enabled with the DDRAM_RDCACHE_EN macro.
package ddram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_CMD  = 2'd1,
    RD_CMD  = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  // DDR3 word address of ROM byte 0 (byte address 0x3000_0000)
  localparam logic [28:0] DDRAM_BASE_DEFAULT = 29'h0600_0000;

  // Byte enables for a 16-bit lane selected by addr[2:1]
  function automatic logic [7:0] be16(input logic [1:0] lane);
    return 8'b0000_0011 << {lane, 1'b0};
  endfunction

  // Pick one byte out of a 64-bit word
  function automatic logic [7:0] sel8(input logic [63:0] line, input logic [2:0] byte_sel);
    return line[{byte_sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ddram_rdline.sv
// One-line read cache: valid/tag/data storage, hit compare, fill and
// write-through byte merge. Only compiled when DDRAM_RDCACHE_EN is defined.
`ifdef DDRAM_RDCACHE_EN
module ddram_rdline (
  input  logic        clk_ram,
  input  logic        rst,
  input  logic [24:0] lookup_tag,
  output logic        hit,
  output logic [63:0] line_data,
  input  logic        fill_en,
  input  logic [24:0] fill_tag,
  input  logic [63:0] fill_data,
  input  logic        wt_en,
  input  logic [24:0] wt_tag,
  input  logic [63:0] wt_data,
  input  logic [7:0]  wt_be
);

  logic        valid_reg;
  logic [24:0] tag_reg;
  logic [63:0] data_reg;
  logic [63:0] merged;

  // Byte-wise merge of write data into the stored line
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = wt_be[gi] ? wt_data[gi*8 +: 8] : data_reg[gi*8 +: 8];
    end
  endgenerate

  assign hit       = valid_reg && (tag_reg == lookup_tag);
  assign line_data = data_reg;

  // Line storage: fill on read return, write-through on matching write
  always_ff @(posedge clk_ram or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else if (fill_en) begin
      valid_reg <= 1'b1;
      tag_reg   <= fill_tag;
      data_reg  <= fill_data;
    end else if (wt_en && valid_reg && (tag_reg == wt_tag)) begin
      data_reg  <= merged;
    end
  end

endmodule
`endif

// File: rtl/ddram_toggle_bridge.sv
// Toggle-handshake ROM port responder onto the 64-bit DDR3 Avalon port.
// Define DDRAM_RDCACHE_EN to add the one-line read cache.
module ddram_toggle_bridge
  import ddram_bridge_pkg::*;
#(
  parameter logic [28:0] BASE_ADDR = DDRAM_BASE_DEFAULT
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  input  logic [27:0] wraddr,
  input  logic [15:0] din,
  input  logic        we_req,
  output logic        we_ack,
  input  logic [27:0] rdaddr,
  output logic [7:0]  dout,
  input  logic        rd_req,
  output logic        rd_ack,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  state_t      state_reg, state_next;
  logic        we_ack_reg, we_ack_next;
  logic        rd_ack_reg, rd_ack_next;
  logic [7:0]  dout_reg, dout_next;
  logic        rd_cmd_reg, rd_cmd_next;
  logic        wr_cmd_reg, wr_cmd_next;
  logic [28:0] addr_reg, addr_next;
  logic [63:0] din_reg, din_next;
  logic [7:0]  be_reg, be_next;
  logic [27:0] lat_addr_reg, lat_addr_next;

  logic        we_pend, rd_pend;
  logic        fill_en, wt_en;
  logic        cache_hit;
  logic [63:0] line_data;

  assign we_pend = (we_req != we_ack_reg);
  assign rd_pend = (rd_req != rd_ack_reg);
  assign fill_en = (state_reg == RD_WAIT) && DDRAM_DOUT_READY;
  assign wt_en   = (state_reg == WR_CMD) && !DDRAM_BUSY;

`ifdef DDRAM_RDCACHE_EN
  ddram_rdline u_rdline (
    .clk_ram    (DDRAM_CLK),
    .rst        (reset),
    .lookup_tag (rdaddr[27:3]),
    .hit        (cache_hit),
    .line_data  (line_data),
    .fill_en    (fill_en),
    .fill_tag   (lat_addr_reg[27:3]),
    .fill_data  (DDRAM_DOUT),
    .wt_en      (wt_en),
    .wt_tag     (lat_addr_reg[27:3]),
    .wt_data    (din_reg),
    .wt_be      (be_reg)
  );
`else
  assign cache_hit = 1'b0;
  assign line_data = '0;
`endif

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      we_ack_reg   <= 1'b0;
      rd_ack_reg   <= 1'b0;
      dout_reg     <= '0;
      rd_cmd_reg   <= 1'b0;
      wr_cmd_reg   <= 1'b0;
      addr_reg     <= '0;
      din_reg      <= '0;
      be_reg       <= '0;
      lat_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      we_ack_reg   <= we_ack_next;
      rd_ack_reg   <= rd_ack_next;
      dout_reg     <= dout_next;
      rd_cmd_reg   <= rd_cmd_next;
      wr_cmd_reg   <= wr_cmd_next;
      addr_reg     <= addr_next;
      din_reg      <= din_next;
      be_reg       <= be_next;
      lat_addr_reg <= lat_addr_next;
    end
  end

  // Next-state and command decode; writes win over reads in IDLE
  always_comb begin
    state_next    = state_reg;
    we_ack_next   = we_ack_reg;
    rd_ack_next   = rd_ack_reg;
    dout_next     = dout_reg;
    rd_cmd_next   = rd_cmd_reg;
    wr_cmd_next   = wr_cmd_reg;
    addr_next     = addr_reg;
    din_next      = din_reg;
    be_next       = be_reg;
    lat_addr_next = lat_addr_reg;
    case (state_reg)
      IDLE: begin
        if (we_pend) begin
          state_next    = WR_CMD;
          wr_cmd_next   = 1'b1;
          lat_addr_next = wraddr;
          addr_next     = BASE_ADDR + {4'b0000, wraddr[27:3]};
          din_next      = {4{din}};
          be_next       = be16(wraddr[2:1]);
        end else if (rd_pend) begin
          lat_addr_next = rdaddr;
          if (cache_hit) begin
            dout_next   = sel8(line_data, rdaddr[2:0]);
            rd_ack_next = ~rd_ack_reg;
          end else begin
            state_next  = RD_CMD;
            rd_cmd_next = 1'b1;
            addr_next   = BASE_ADDR + {4'b0000, rdaddr[27:3]};
          end
        end
      end
      WR_CMD: begin
        if (wt_en) begin
          wr_cmd_next = 1'b0;
          we_ack_next = ~we_ack_reg;
          state_next  = IDLE;
        end
      end
      RD_CMD: begin
        if (!DDRAM_BUSY) begin
          rd_cmd_next = 1'b0;
          state_next  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (fill_en) begin
          dout_next   = sel8(DDRAM_DOUT, lat_addr_reg[2:0]);
          rd_ack_next = ~rd_ack_reg;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign we_ack         = we_ack_reg;
  assign rd_ack         = rd_ack_reg;
  assign dout           = dout_reg;
  assign DDRAM_RD       = rd_cmd_reg;
  assign DDRAM_WE       = wr_cmd_reg;
  assign DDRAM_ADDR     = addr_reg;
  assign DDRAM_DIN      = din_reg;
  assign DDRAM_BE       = be_reg;
  assign DDRAM_BURSTCNT = 8'd1;

endmodule

// File: tb/tb_ddram_toggle_bridge.sv
// Self-checking bench for ddram_toggle_bridge with a small DDR3 responder.
// Expectations adapt to whether DDRAM_RDCACHE_EN is defined.
module tb_ddram_toggle_bridge;

`ifdef DDRAM_RDCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [27:0] wraddr = '0;
  logic [15:0] din = '0;
  logic        we_req = 1'b0;
  logic        we_ack;
  logic [27:0] rdaddr = '0;
  logic [7:0]  dout;
  logic        rd_req = 1'b0;
  logic        rd_ack;
  logic        DDRAM_BUSY = 1'b0;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT = '0;
  logic        DDRAM_DOUT_READY = 1'b0;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  int checks = 0;
  int failures = 0;

  ddram_toggle_bridge dut (
    .DDRAM_CLK        (clk),
    .reset            (reset),
    .wraddr           (wraddr),
    .din              (din),
    .we_req           (we_req),
    .we_ack           (we_ack),
    .rdaddr           (rdaddr),
    .dout             (dout),
    .rd_req           (rd_req),
    .rd_ack           (rd_ack),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_WE         (DDRAM_WE)
  );

  always #5 clk = ~clk;

  // Command monitor: counts command cycles and remembers the accepted read address
  int          rd_total = 0;
  int          wr_total = 0;
  logic [28:0] last_rd_addr = '0;
  always @(posedge clk) begin
    if (DDRAM_RD) rd_total = rd_total + 1;
    if (DDRAM_WE) wr_total = wr_total + 1;
    if (DDRAM_RD && !DDRAM_BUSY) last_rd_addr = DDRAM_ADDR;
  end

  // DDR3 responder: 16-word memory, fixed read latency, optional spurious ready
  logic [63:0] mem [16];
  bit          mem_init = 1'b0;
  bit          rsp_pend = 1'b0;
  int          rsp_cnt = 0;
  logic [3:0]  rsp_idx = '0;
  int          spur_cnt = 0;
  int          spur_done = 0;
  always @(negedge clk) begin
    DDRAM_DOUT_READY = 1'b0;
    if (reset) begin
      rsp_pend = 1'b0;
      if (!mem_init) begin
        for (int i = 0; i < 16; i++) mem[i] = 64'h0011_2233_4455_6677;
        mem[0] = 64'h8877_6655_4433_2211;
        mem[1] = 64'hF0E1_D2C3_B4A5_9687;
        mem_init = 1'b1;
      end
    end else begin
      if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          DDRAM_DOUT_READY = 1'b1;
          DDRAM_DOUT = mem[rsp_idx];
          rsp_pend = 1'b0;
        end else begin
          rsp_cnt = rsp_cnt - 1;
        end
      end else if (spur_cnt != spur_done) begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT = 64'hDEAD_BEEF_CAFE_F00D;
        spur_done = spur_cnt;
      end
      if (DDRAM_RD && !DDRAM_BUSY && !rsp_pend) begin
        rsp_pend = 1'b1;
        rsp_cnt = 9;
        rsp_idx = DDRAM_ADDR[3:0];
      end
      if (DDRAM_WE && !DDRAM_BUSY) begin
        for (int b = 0; b < 8; b++)
          if (DDRAM_BE[b]) mem[DDRAM_ADDR[3:0]][8*b +: 8] = DDRAM_DIN[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // All outputs at their reset values, packed for one comparison
  task automatic chk_reset_outputs(input string name);
    chk(name, {we_ack, rd_ack, dout, DDRAM_RD, DDRAM_WE, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_BURSTCNT},
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 29'h0, 64'h0, 8'h00, 8'h01});
  endtask

  typedef struct {
    logic        is_wr;
    logic [27:0] addr;
    logic [15:0] wdata;
    logic [28:0] exp_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_din;
    logic [7:0]  exp_dout;
    logic        exp_hit;
  } vec_t;

  task automatic do_write(input vec_t v);
    int n;
    int wr_base;
    wr_base = wr_total;
    wraddr = v.addr;
    din = v.wdata;
    we_req = ~we_req;
    @(negedge clk);
    n = 1;
    chk("wr_cmd", {DDRAM_WE, DDRAM_RD, DDRAM_ADDR, DDRAM_BE, DDRAM_DIN},
        {1'b1, 1'b0, v.exp_addr, v.exp_be, v.exp_din});
    while (we_ack != we_req && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("we_ack", we_ack, we_req);
    chk("wr_latency", n, 2);
    chk("wr_cycles", wr_total - wr_base, 1);
    chk("wr_deassert", DDRAM_WE, 1'b0);
  endtask

  task automatic do_read(input vec_t v);
    int n;
    int rd_base;
    int exp_rds;
    int exp_lat;
    exp_rds = (CACHE && v.exp_hit) ? 0 : 1;
    exp_lat = (CACHE && v.exp_hit) ? 1 : 12;
    rd_base = rd_total;
    rdaddr = v.addr;
    rd_req = ~rd_req;
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (rd_ack != rd_req && n < 100);
    chk("rd_ack", rd_ack, rd_req);
    chk("rd_dout", dout, v.exp_dout);
    chk("rd_cycles", rd_total - rd_base, exp_rds);
    chk("rd_latency", n, exp_lat);
    if (exp_rds != 0) chk("rd_addr", last_rd_addr, v.exp_addr);
  endtask

  vec_t vecs [7];

  initial begin
    int n;
    int rd_base;
    int stable;
    logic prev_ack;

    vecs[0] = '{1'b1, 28'h000_0006, 16'hA55A, 29'h0600_0000, 8'hC0, 64'hA55A_A55A_A55A_A55A, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 28'h000_0013, 16'h0000, 29'h0600_0002, 8'h00, 64'h0, 8'h44, 1'b0};
    vecs[2] = '{1'b0, 28'h000_0010, 16'h0000, 29'h0600_0002, 8'h00, 64'h0, 8'h77, 1'b1};
    vecs[3] = '{1'b1, 28'h000_000A, 16'h1234, 29'h0600_0001, 8'h0C, 64'h1234_1234_1234_1234, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 28'h000_000B, 16'h0000, 29'h0600_0001, 8'h00, 64'h0, 8'h12, 1'b0};
    vecs[5] = '{1'b0, 28'h000_000F, 16'h0000, 29'h0600_0001, 8'h00, 64'h0, 8'hF0, 1'b1};
    vecs[6] = '{1'b0, 28'h000_0015, 16'h0000, 29'h0600_0002, 8'h00, 64'h0, 8'h22, 1'b0};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i]);
      else do_read(vecs[i]);
      @(negedge clk);
    end

    // Simultaneous write and read toggles: write goes first, then read sees new data
    rd_base = rd_total;
    wraddr = 28'h000_0012;
    din = 16'hBEEF;
    rdaddr = 28'h000_0013;
    we_req = ~we_req;
    rd_req = ~rd_req;
    @(negedge clk);
    chk("both_wr_first", {DDRAM_WE, DDRAM_RD, DDRAM_ADDR, DDRAM_BE}, {1'b1, 1'b0, 29'h0600_0002, 8'h0C});
    n = 0;
    while ((we_ack != we_req || rd_ack != rd_req) && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("both_acks", {we_ack, rd_ack}, {we_req, rd_req});
    chk("both_dout", dout, 8'hBE);
    chk("both_rd_cycles", rd_total - rd_base, CACHE ? 0 : 1);
    @(negedge clk);

    // BUSY stall during RD_CMD: command and address held until accepted
    rd_base = rd_total;
    DDRAM_BUSY = 1'b1;
    rdaddr = 28'h000_0000;
    rd_req = ~rd_req;
    stable = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (DDRAM_RD && DDRAM_ADDR == 29'h0600_0000) stable = stable + 1;
      if (c == 4) begin
        @(posedge clk);
        #1 DDRAM_BUSY = 1'b0;
      end
    end
    chk("busy_rd_stable", stable, 6);
    n = 0;
    while (rd_ack != rd_req && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("busy_rd_ack", rd_ack, rd_req);
    chk("busy_rd_cycles", rd_total - rd_base, 6);
    chk("busy_rd_dout", dout, 8'h11);
    @(negedge clk);
    do_read('{1'b0, 28'h000_0007, 16'h0, 29'h0600_0000, 8'h00, 64'h0, 8'hA5, 1'b1});

    // Spurious DOUT_READY while idle must not move the handshake
    prev_ack = rd_ack;
    spur_cnt = spur_cnt + 1;
    repeat (4) @(negedge clk);
    chk("spurious_ack", rd_ack, prev_ack);
    chk("spurious_dout", dout, 8'hA5);

    // Reset in RD_WAIT aborts at once; a later read goes back to DDR3
    rd_base = rd_total;
    rdaddr = 28'h000_0008;
    rd_req = ~rd_req;
    n = 0;
    while (rd_total == rd_base && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("rst_rd_issued", rd_total - rd_base, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd_req = 1'b0;
    we_req = 1'b0;
    #1;
    chk_reset_outputs("reset_mid_rd");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("post_rst_idle", {rd_ack, we_ack, DDRAM_RD}, 3'b000);
    do_read('{1'b0, 28'h000_0007, 16'h0, 29'h0600_0000, 8'h00, 64'h0, 8'hA5, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
